// File: rtl/vga_pkg.sv
// Shared VGA raster constants (640x480@60 defaults), coordinate type and the sync bundle
// that travels through the output delay pipe.
package vga_pkg;

  localparam int unsigned H_VIS_DEF  = 640;
  localparam int unsigned H_FP_DEF   = 16;
  localparam int unsigned H_SYNC_DEF = 96;
  localparam int unsigned H_BP_DEF   = 48;
  localparam int unsigned V_VIS_DEF  = 480;
  localparam int unsigned V_FP_DEF   = 10;
  localparam int unsigned V_SYNC_DEF = 2;
  localparam int unsigned V_BP_DEF   = 33;

  localparam int unsigned H_TOTAL  = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL  = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int unsigned HS_START = H_VIS_DEF + H_FP_DEF;
  localparam int unsigned HS_END   = HS_START + H_SYNC_DEF;
  localparam int unsigned VS_START = V_VIS_DEF + V_FP_DEF;
  localparam int unsigned VS_END   = VS_START + V_SYNC_DEF;

  localparam int unsigned COORD_MAX = 1024;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_t;

  localparam sync_t SYNC_RST = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

  // Active-low sync level: low only inside [start, stop).
  function automatic logic sync_level(int unsigned pos, int unsigned start, int unsigned stop);
    return !((pos >= start) && (pos < stop));
  endfunction

endpackage

// File: rtl/vga_sync_pipe.sv
// Pixel-tick delay line for hs/vs/blank so they line up with the registered RGB path.
module vga_sync_pipe
  import vga_pkg::*;
#(
  parameter int unsigned SYNC_DELAY = 1
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  ce_i,
  input  sync_t d_i,
  output sync_t q_o
);

  if (SYNC_DELAY == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_ni, ce_i};
    assign q_o = d_i;
  end else begin : g_pipe
    sync_t stage_q [SYNC_DELAY];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < SYNC_DELAY; i++) stage_q[i] <= SYNC_RST;
      end else if (ce_i) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < SYNC_DELAY; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[SYNC_DELAY-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, h/v scan counters, sync/blank decode with
// alignment delay, and a once-per-frame start strobe.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned H_VIS      = H_VIS_DEF,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_VIS      = V_VIS_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter int unsigned SYNC_DELAY = 1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  output logic       pixel_clk,
  output logic       pixel_ce,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start
);

  localparam int unsigned HTotal  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HsStart = H_VIS + H_FP;
  localparam int unsigned HsEnd   = HsStart + H_SYNC;
  localparam int unsigned VsStart = V_VIS + V_FP;
  localparam int unsigned VsEnd   = VsStart + V_SYNC;
  localparam int unsigned DivW    = $clog2(CLK_DIV);

  localparam logic [DivW-1:0] DivMax  = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(CLK_DIV / 2);
  localparam coord_t          HMax    = coord_t'(HTotal - 1);
  localparam coord_t          VMax    = coord_t'(VTotal - 1);

  if (HTotal > COORD_MAX || VTotal > COORD_MAX) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit scan counters");
  end
  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be even and >= 2");
  end

  logic [DivW-1:0] div_q, div_d;
  coord_t          hc_q, hc_d, vc_q, vc_d;
  logic            pclk_q, fs_q;
  logic            pce;
  sync_t           raw, pipe_q;

  assign pce = (div_q == DivMax);

  always_comb begin
    div_d = pce ? '0 : div_q + 1'b1;
    hc_d  = hc_q;
    vc_d  = vc_q;
    if (pce) begin
      if (hc_q == HMax) begin
        hc_d = '0;
        vc_d = (vc_q == VMax) ? '0 : vc_q + 1'b1;
      end else begin
        hc_d = hc_q + 1'b1;
      end
    end
  end

  // pixel_clk falls on the counter-advance edge and rises mid-pixel, once DrawX/Y are settled.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_q  <= '0;
      hc_q   <= '0;
      vc_q   <= '0;
      pclk_q <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      hc_q   <= hc_d;
      vc_q   <= vc_d;
      pclk_q <= (div_d >= DivHalf);
      fs_q   <= pce && (hc_q == HMax) && (vc_q == VMax);
    end
  end

  always_comb begin
    raw       = SYNC_RST;
    raw.blank = (32'(hc_q) < H_VIS) && (32'(vc_q) < V_VIS);
    raw.hs    = sync_level(32'(hc_q), HsStart, HsEnd);
    raw.vs    = sync_level(32'(vc_q), VsStart, VsEnd);
  end

  vga_sync_pipe #(
    .SYNC_DELAY(SYNC_DELAY)
  ) u_sync_pipe (
    .clk_i (Clk),
    .rst_ni(Reset_n),
    .ce_i  (pce),
    .d_i   (raw),
    .q_o   (pipe_q)
  );

  assign pixel_clk   = pclk_q;
  assign pixel_ce    = pce;
  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign blank       = pipe_q.blank;
  assign hs          = pipe_q.hs;
  assign vs          = pipe_q.vs;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing, a shrunken raster for full-frame and mid-frame reset,
// and a CLK_DIV=4 / SYNC_DELAY=2 override.
module tb_vga_timing_gen;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0_n, rst1_n, rst2_n;
  logic       pclk0, pce0, blank0, hs0, vs0, fs0;
  logic       pclk1, pce1, blank1, hs1, vs1, fs1;
  logic       pclk2, pce2, blank2, hs2, vs2, fs2;
  logic [9:0] x0, y0, x1, y1, x2, y2;

  vga_timing_gen u_dut0 (
    .Clk(clk), .Reset_n(rst0_n), .pixel_clk(pclk0), .pixel_ce(pce0), .DrawX(x0), .DrawY(y0),
    .blank(blank0), .hs(hs0), .vs(vs0), .frame_start(fs0)
  );

  // Small raster: 24 x 14 total, hsync 18..21, vsync rows 10..11.
  vga_timing_gen #(
    .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(2), .V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) u_dut1 (
    .Clk(clk), .Reset_n(rst1_n), .pixel_clk(pclk1), .pixel_ce(pce1), .DrawX(x1), .DrawY(y1),
    .blank(blank1), .hs(hs1), .vs(vs1), .frame_start(fs1)
  );

  vga_timing_gen #(
    .CLK_DIV(4), .SYNC_DELAY(2),
    .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(2), .V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) u_dut2 (
    .Clk(clk), .Reset_n(rst2_n), .pixel_clk(pclk2), .pixel_ce(pce2), .DrawX(x2), .DrawY(y2),
    .blank(blank2), .hs(hs2), .vs(vs2), .frame_start(fs2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int k;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  task automatic check_rst(input string tag, input int x, input int y, input int pclk,
                           input int pce, input int blank, input int hs, input int vs,
                           input int fs);
    check({tag, " DrawX"}, x, 0);
    check({tag, " DrawY"}, y, 0);
    check({tag, " pixel_clk"}, pclk, 0);
    check({tag, " pixel_ce"}, pce, 0);
    check({tag, " blank"}, blank, 0);
    check({tag, " hs"}, hs, 1);
    check({tag, " vs"}, vs, 1);
    check({tag, " frame_start"}, fs, 0);
  endtask

  // Edge count after release -> expected outputs of the default-timing instance.
  typedef struct {
    int k;
    int x;
    int y;
    int pclk;
    int pce;
    int blank;
    int hs;
    int vs;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int fs_cnt, fs_at, fs_pos_bad, vs_low, pclk_hi, phase_bad, last_chg, hs_low, hs_fall_x;
    int guard, pce_cnt, x_k1, x_k2, y_k2;
    logic [9:0] px, py;
    logic pp, ph;
    bit b2[0:100], h2[0:100], c2[0:100];

    vecs.push_back('{0,    0,   0, 0, 0, 0, 1, 1});
    vecs.push_back('{1,    0,   0, 1, 1, 0, 1, 1});
    vecs.push_back('{2,    1,   0, 0, 0, 1, 1, 1});
    vecs.push_back('{3,    1,   0, 1, 1, 1, 1, 1});
    vecs.push_back('{1280, 640, 0, 0, 0, 1, 1, 1});
    vecs.push_back('{1282, 641, 0, 0, 0, 0, 1, 1});
    vecs.push_back('{1312, 656, 0, 0, 0, 0, 1, 1});
    vecs.push_back('{1314, 657, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{1504, 752, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{1506, 753, 0, 0, 0, 0, 1, 1});
    vecs.push_back('{1598, 799, 0, 0, 0, 0, 1, 1});
    vecs.push_back('{1600, 0,   1, 0, 0, 0, 1, 1});
    vecs.push_back('{1602, 1,   1, 0, 0, 1, 1, 1});

    rst0_n = 1'b0;
    rst1_n = 1'b0;
    rst2_n = 1'b0;
    k = 0;
    repeat (10) @(negedge clk);
    check_rst("rst d0", x0, y0, pclk0, pce0, blank0, hs0, vs0, fs0);
    check_rst("rst d1", x1, y1, pclk1, pce1, blank1, hs1, vs1, fs1);
    check_rst("rst d2", x2, y2, pclk2, pce2, blank2, hs2, vs2, fs2);

    // Default timing: vector table over the first line and into the second.
    rst0_n = 1'b1;
    k = 0;
    fs_cnt = 0;
    foreach (vecs[i]) begin
      while (k < vecs[i].k) begin
        tick();
        if (fs0) fs_cnt++;
      end
      check($sformatf("vec k=%0d DrawX", vecs[i].k), x0, vecs[i].x);
      check($sformatf("vec k=%0d DrawY", vecs[i].k), y0, vecs[i].y);
      check($sformatf("vec k=%0d pixel_clk", vecs[i].k), pclk0, vecs[i].pclk);
      check($sformatf("vec k=%0d pixel_ce", vecs[i].k), pce0, vecs[i].pce);
      check($sformatf("vec k=%0d blank", vecs[i].k), blank0, vecs[i].blank);
      check($sformatf("vec k=%0d hs", vecs[i].k), hs0, vecs[i].hs);
      check($sformatf("vec k=%0d vs", vecs[i].k), vs0, vecs[i].vs);
    end
    hs_low = 0;
    hs_fall_x = -1;
    ph = hs0;
    repeat (1600) begin
      tick();
      if (fs0) fs_cnt++;
      if (!hs0) hs_low++;
      if (!hs0 && ph) hs_fall_x = x0;
      ph = hs0;
    end
    check("d0 hs low Clk samples per line", hs_low, 192);
    check("d0 DrawX at hs fall", hs_fall_x, 657);
    check("d0 no frame_start in first lines", fs_cnt, 0);

    // Small raster: one full frame (336 pixel ticks = 672 Clk).
    rst1_n = 1'b1;
    k = 0;
    fs_cnt = 0;
    fs_at = -1;
    fs_pos_bad = 0;
    vs_low = 0;
    pclk_hi = 0;
    phase_bad = 0;
    last_chg = 0;
    px = x1;
    py = y1;
    pp = pclk1;
    repeat (680) begin
      tick();
      if (x1 != px || y1 != py) last_chg = k;
      if (pclk1 && !pp && (k - last_chg) != 1) phase_bad++;
      if (k <= 672) begin
        if (!vs1) vs_low++;
        if (pclk1) pclk_hi++;
      end
      if (fs1) begin
        fs_cnt++;
        fs_at = k;
        if (x1 != 0 || y1 != 0) fs_pos_bad++;
      end
      px = x1;
      py = y1;
      pp = pclk1;
    end
    check("d1 vs low Clk samples per frame", vs_low, 96);
    check("d1 pixel_clk high samples", pclk_hi, 336);
    check("d1 pixel_clk phase errors", phase_bad, 0);
    check("d1 frame_start count", fs_cnt, 1);
    check("d1 frame_start edge", fs_at, 672);
    check("d1 frame_start not at 0/0", fs_pos_bad, 0);

    // Mid-frame asynchronous reset.
    guard = 0;
    while (!(x1 == 20 && y1 == 10) && guard < 2000) begin
      tick();
      guard++;
    end
    check("d1 reached x20 y10 in time", int'(guard < 2000), 1);
    rst1_n = 1'b0;
    #1;
    check_rst("async rst d1", x1, y1, pclk1, pce1, blank1, hs1, vs1, fs1);
    repeat (3) tick();
    rst1_n = 1'b1;
    k = 0;
    fs_cnt = 0;
    x_k1 = -1;
    x_k2 = -1;
    y_k2 = -1;
    repeat (600) begin
      tick();
      if (fs1) fs_cnt++;
      if (k == 1) x_k1 = x1;
      if (k == 2) begin
        x_k2 = x1;
        y_k2 = y1;
      end
    end
    check("d1 restart DrawX k1", x_k1, 0);
    check("d1 restart DrawX k2", x_k2, 1);
    check("d1 restart DrawY k2", y_k2, 0);
    check("d1 no frame_start after restart", fs_cnt, 0);

    // CLK_DIV=4, SYNC_DELAY=2 override.
    rst2_n = 1'b1;
    k = 0;
    pce_cnt = 0;
    phase_bad = 0;
    last_chg = 0;
    px = x2;
    pp = pclk2;
    repeat (100) begin
      tick();
      if (pce2) pce_cnt++;
      if (x2 != px) last_chg = k;
      if (pclk2 && !pp && (k - last_chg) != 2) phase_bad++;
      b2[k] = blank2;
      h2[k] = hs2;
      c2[k] = pce2;
      px = x2;
      pp = pclk2;
    end
    check("d2 pixel_ce count in 100 Clk", pce_cnt, 25);
    check("d2 pixel_ce k2", int'(c2[2]), 0);
    check("d2 pixel_ce k3", int'(c2[3]), 1);
    check("d2 blank k7", int'(b2[7]), 0);
    check("d2 blank k8", int'(b2[8]), 1);
    check("d2 blank k71", int'(b2[71]), 1);
    check("d2 blank k72", int'(b2[72]), 0);
    check("d2 hs k79", int'(h2[79]), 1);
    check("d2 hs k80", int'(h2[80]), 0);
    check("d2 hs k95", int'(h2[95]), 0);
    check("d2 hs k96", int'(h2[96]), 1);
    check("d2 pixel_clk phase errors", phase_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster source for the display path: derives the pixel-rate clock and pixel enable from the 50 MHz system clock.
- Scans horizontal/vertical counters and presents DrawX/DrawY and blank to color_mapper.
- Drives VGA hs/vs to the DAC/connector, with hs/vs/blank delayed to line up with color_mapper's registered RGB output.
- Also emits a one-cycle frame_start pulse, used by sprite/ball motion logic to update once per frame.

Parameters:
- CLK_DIV, 2, Clk cycles per pixel (even, >=2).
- H_VIS, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, hsync width.
- H_BP, 48, horizontal back porch.
- V_VIS, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vsync width.
- V_BP, 33, vertical back porch.
- SYNC_DELAY, 1, pixel ticks of delay on hs/vs/blank (matches color_mapper's RGB register).

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset_n  in  1  asynchronous active-low reset.
- pixel_clk  out  1  registered pixel-rate square wave, feeds color_mapper.
- pixel_ce  out  1  one-Clk-cycle pixel-advance strobe.
- DrawX  out  10  current column (0..H_TOTAL-1).
- DrawY  out  10  current row (0..V_TOTAL-1).
- blank  out  1  1 = visible region (display enable), delayed.
- hs  out  1  horizontal sync, active-low, delayed.
- vs  out  1  vertical sync, active-low, delayed.
- frame_start  out  1  one-Clk pulse at end of last pixel of frame.

Behaviour:
- Derived constants: H_TOTAL = sum of H_* (800 by default); V_TOTAL = sum of V_* (525 by default).
- Reset (async, Reset_n=0):
  - div_cnt, hc, vc = 0; pixel_clk = 0; pixel_ce = 0; frame_start = 0.
  - Delay pipe stages: hs = 1, vs = 1, blank = 0.
  - Reset may assert mid-line; all state returns to these values immediately.
  - After release, the first pixel_ce occurs CLK_DIV Clk cycles later.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pixel_ce = (div_cnt == CLK_DIV-1), decoded from the register.
  - pixel_clk register loads (div_cnt_next >= CLK_DIV/2).
  - So pixel_clk falls at the edge where counters advance and rises CLK_DIV/2 Clk cycles later, when DrawX/DrawY are stable.
- Counters, on Clk edges where pixel_ce = 1:
  - hc increments; at H_TOTAL-1, hc wraps to 0 and vc increments.
  - vc wraps to 0 after V_TOTAL-1 when hc also wraps.
  - DrawX = hc, DrawY = vc (direct register outputs, no delay).
- Raw decodes from the registered counters:
  - blank_raw = (hc < H_VIS) && (vc < V_VIS).
  - hs_raw = 0 iff H_VIS+H_FP <= hc < H_VIS+H_FP+H_SYNC (656..751).
  - vs_raw = 0 iff V_VIS+V_FP <= vc < V_VIS+V_FP+V_SYNC (490..491).
- Delay pipe:
  - SYNC_DELAY stages, shifting only on pixel_ce.
  - hs/vs/blank outputs are the last stage.
  - SYNC_DELAY = 0 means raw decodes pass through combinationally.
- frame_start:
  - Registered; high for exactly one Clk cycle following the pixel_ce edge where hc = H_TOTAL-1 and vc = V_TOTAL-1, i.e. coincident with hc = vc = 0.
  - Never asserted during reset or in the first frame's start after reset.
- Widths: hc/vc are 10 bits; parameter combinations with H_TOTAL or V_TOTAL > 1024 are illegal (elaboration assertion).

Decomposition:
- Package vga_pkg:
  - Default timing constants (H_VIS..V_BP).
  - Derived H_TOTAL/V_TOTAL, HS_START/HS_END, VS_START/VS_END.
  - Coordinate typedef coord_t = logic [9:0].
- Sub-module vga_sync_pipe:
  - Parameterised SYNC_DELAY-deep, 3-bit-wide shift register, advancing on pixel_ce.
  - Async active-low reset to {hs=1, vs=1, blank=0}.

Test Plan:
- Reset held 10 cycles, then released:
  - During reset: hs=1, vs=1, blank=0, DrawX=0, DrawY=0, pixel_clk=0.
  - First pixel_ce at Clk cycle 2 after release.
  - blank=1 after SYNC_DELAY pixel ticks.
- Run one full line:
  - DrawX goes 0..799, then 0 with DrawY incremented.
  - blank falls when DrawX (delayed by 1) = 640.
  - hs is low for exactly 96 pixel ticks, beginning when the delayed DrawX = 656.
- Run one full frame (420000 pixel ticks, 840000 Clk):
  - vs is low for exactly 2 lines (rows 490, 491).
  - frame_start pulses exactly once, one Clk wide, as DrawX/DrawY return to 0/0.
- pixel_clk phase check:
  - At every pixel_clk rising edge, DrawX/DrawY have been stable for CLK_DIV/2 Clk cycles.
  - Period is CLK_DIV Clk cycles with 50% duty.
- Reset asserted at DrawX=700, DrawY=300:
  - Outputs return to reset values asynchronously within the same cycle.
  - After release, the scan restarts from 0/0 with no frame_start pulse.
- Parameter override CLK_DIV=4, SYNC_DELAY=2:
  - pixel_ce every 4 Clk cycles.
  - blank/hs/vs lag the raw decodes by exactly 2 pixel ticks (8 Clk).
